// File: rtl/fa_pipe_seg.sv
// Segmented pipelined adder/subtractor: one SEG-bit slice per stage, ripple carry between
// stages, operand/result skew so each transaction leaves aligned, optional signed saturation.
module fa_pipe_seg #(
   parameter int WIDTH = 24,
   parameter int SEG   = 12
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   input  logic             SAT,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             OVF
);

   localparam int NSEG = WIDTH / SEG;

   // Stage k holds the transaction after segment k has been added; stage NSEG-1 is the output.
   logic [WIDTH-1:0] r_a   [NSEG];
   logic [WIDTH-1:0] r_b   [NSEG];
   logic [WIDTH-1:0] r_s   [NSEG];
   logic             r_c   [NSEG];
   logic             r_v   [NSEG];
   logic             r_sub [NSEG];
   logic             r_sat [NSEG];
   logic             r_ovf;

   logic [WIDTH-1:0] w_in_a   [NSEG];
   logic [WIDTH-1:0] w_in_b   [NSEG];
   logic [WIDTH-1:0] w_in_s   [NSEG];
   logic             w_in_c   [NSEG];
   logic             w_in_v   [NSEG];
   logic             w_in_sub [NSEG];
   logic             w_in_sat [NSEG];

   logic [WIDTH-1:0] w_nxt_s  [NSEG];
   logic             w_nxt_c  [NSEG];
   logic             w_nxt_ovf;
   logic             w_adv;

   logic [SEG:0]     w_seg_sum;
   logic [SEG-1:0]   w_seg_b;
   logic             w_sign_a;
   logic             w_sign_b;

   assign w_adv    = !r_v[NSEG-1] || OUT_READY;
   assign IN_READY = w_adv;

   // Stage 0 sees the ports; SUB forces carry-in high so A + ~B + 1 = A - B.
   always_comb begin
      w_in_a[0]   = A;
      w_in_b[0]   = B;
      w_in_s[0]   = '0;
      w_in_c[0]   = SUB | CIN;
      w_in_v[0]   = IN_VALID;
      w_in_sub[0] = SUB;
      w_in_sat[0] = SAT;
      for (int k = 1; k < NSEG; k++) begin
         w_in_a[k]   = r_a[k-1];
         w_in_b[k]   = r_b[k-1];
         w_in_s[k]   = r_s[k-1];
         w_in_c[k]   = r_c[k-1];
         w_in_v[k]   = r_v[k-1];
         w_in_sub[k] = r_sub[k-1];
         w_in_sat[k] = r_sat[k-1];
      end
   end

   // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
   always_comb begin
      w_seg_sum = '0;
      w_seg_b   = '0;
      for (int k = 0; k < NSEG; k++) begin
         w_seg_b   = w_in_b[k][k*SEG +: SEG] ^ {SEG{w_in_sub[k]}};
         w_seg_sum = {1'b0, w_in_a[k][k*SEG +: SEG]} + {1'b0, w_seg_b}
                     + {{SEG{1'b0}}, w_in_c[k]};
         w_nxt_s[k]              = w_in_s[k];
         w_nxt_s[k][k*SEG +: SEG] = w_seg_sum[SEG-1:0];
         w_nxt_c[k]              = w_seg_sum[SEG];
      end

      w_sign_a  = w_in_a[NSEG-1][WIDTH-1];
      w_sign_b  = w_in_b[NSEG-1][WIDTH-1] ^ w_in_sub[NSEG-1];
      w_nxt_ovf = (w_sign_a == w_sign_b) && (w_nxt_s[NSEG-1][WIDTH-1] != w_sign_a);
      if (w_in_sat[NSEG-1] && w_nxt_ovf)
         w_nxt_s[NSEG-1] = w_sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples the old
   // value of its predecessor on the same edge.
   // NOTE: all stage registers, datapath included, are cleared so no stale operand survives reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int k = 0; k < NSEG; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_s[k]   <= '0;
            r_c[k]   <= 1'b0;
            r_v[k]   <= 1'b0;
            r_sub[k] <= 1'b0;
            r_sat[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < NSEG; k++) begin
            r_a[k]   <= w_in_a[k];
            r_b[k]   <= w_in_b[k];
            r_s[k]   <= w_nxt_s[k];
            r_c[k]   <= w_nxt_c[k];
            r_v[k]   <= w_in_v[k];
            r_sub[k] <= w_in_sub[k];
            r_sat[k] <= w_in_sat[k];
         end
         r_ovf <= w_nxt_ovf;
      end
   end

   assign OUT_VALID = r_v[NSEG-1];
   assign SUM       = r_s[NSEG-1];
   assign COUT      = r_c[NSEG-1];
   assign OVF       = r_ovf;

endmodule

// File: tb/tb_fa_pipe_seg.sv
// Self-checking bench for fa_pipe_seg: arithmetic reference model, in-order scoreboard,
// stall/hold and reset checks, directed corner cases plus randomized traffic.
module tb_fa_pipe_seg;

   localparam int W    = 24;
   localparam int SEG  = 12;
   localparam int NSEG = W / SEG;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         sat = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic         held = 1'b0;
   logic [W-1:0] held_sum;
   logic         held_cout;
   logic         held_ovf;
   logic         rand_on = 1'b0;

   fa_pipe_seg #(.WIDTH(W), .SEG(SEG)) dut (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .A(a), .B(b), .CIN(cin), .SUB(sub), .SAT(sat),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .SUM(sum), .COUT(cout), .OVF(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: true signed/unsigned arithmetic, range test for overflow.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub, input logic msat);
      exp_t        e;
      longint      sa, sb, res;
      longint      smax, smin;
      logic [W:0]  full;
      sa   = longint'($signed(ma));
      sb   = longint'($signed(mb));
      smax = (longint'(1) <<< (W-1)) - 1;
      smin = -(longint'(1) <<< (W-1));
      if (msub) begin
         e.sum  = ma - mb;
         e.cout = (ma >= mb);
         res    = sa - sb;
      end else begin
         full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
         e.sum  = full[W-1:0];
         e.cout = full[W];
         res    = sa + sb + longint'(mcin);
      end
      e.ovf = (res > smax) || (res < smin);
      if (msat && e.ovf)
         e.sum = (res > 0) ? W'(smax) : W'(smin);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0: v = '0;
         1: v = '1;
         2: v = 24'h7FFFFF;
         3: v = 24'h800000;
         4: v = {12'($urandom), 12'hFFF};
         default: v = 24'($urandom);
      endcase
      return v;
   endfunction

   // Scoreboard: acceptance/delivery decided at negedge, takes effect on the next posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         held = 1'b0;
      end else begin
         check("in_ready", in_ready, !out_valid || out_ready);
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, held_sum);
            check("hold_cout", cout, held_cout);
            check("hold_ovf", ovf, held_ovf);
         end
         if (q.size() == 0) begin
            check("no_stale", out_valid, 0);
         end else if (out_valid) begin
            check("sb_sum", sum, q[0].sum);
            check("sb_cout", cout, q[0].cout);
            check("sb_ovf", ovf, q[0].ovf);
            if (out_ready) void'(q.pop_front());
         end
         held      = out_valid && !out_ready;
         held_sum  = sum;
         held_cout = cout;
         held_ovf  = ovf;
         if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, sat));
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic tsub, input logic tsat);
      int n = 0;
      a = ta; b = tb; cin = tcin; sub = tsub; sat = tsat;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Pipeline empty, out_ready high: result must appear exactly NSEG edges after acceptance.
   task automatic run_directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub, input logic tsat,
                               input logic [W-1:0] esum, input logic ecout, input logic eovf);
      send(ta, tb, tcin, tsub, tsat);
      for (int i = 0; i < NSEG - 1; i++) begin
         check({name, "_early"}, out_valid, 0);
         @(posedge clk);
         #1;
      end
      check({name, "_valid"}, out_valid, 1);
      check({name, "_sum"}, sum, esum);
      check({name, "_cout"}, cout, ecout);
      check({name, "_ovf"}, ovf, eovf);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         n++;
         @(posedge clk);
      end
      #1 check(name, q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t m;

      // Model pinned against hand-computed values.
      m = model(24'h000FFF, 24'h000001, 0, 0, 0);
      check("pin_carry", {m.sum, m.cout, m.ovf}, {24'h001000, 1'b0, 1'b0});
      m = model(24'h7FFFFF, 24'h000001, 0, 0, 1);
      check("pin_sat_pos", {m.sum, m.cout, m.ovf}, {24'h7FFFFF, 1'b0, 1'b1});
      m = model(24'h800000, 24'h000001, 0, 1, 1);
      check("pin_sat_neg", {m.sum, m.cout, m.ovf}, {24'h800000, 1'b1, 1'b1});

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_in_ready", in_ready, 1);

      run_directed("seg_carry", 24'h000FFF, 24'h000001, 0, 0, 0, 24'h001000, 0, 0);
      run_directed("wrap",      24'hFFFFFF, 24'h000001, 0, 0, 0, 24'h000000, 1, 0);
      run_directed("ovf_raw",   24'h7FFFFF, 24'h000001, 0, 0, 0, 24'h800000, 0, 1);
      run_directed("ovf_sat",   24'h7FFFFF, 24'h000001, 0, 0, 1, 24'h7FFFFF, 0, 1);
      run_directed("sub_neg",   24'h000000, 24'h000001, 0, 1, 0, 24'hFFFFFF, 0, 0);
      run_directed("sub_sat",   24'h800000, 24'h000001, 0, 1, 1, 24'h800000, 1, 1);
      run_directed("sub_cin",   24'h000005, 24'h000003, 1, 1, 0, 24'h000002, 1, 0);

      // Back-to-back burst with a 3-cycle downstream stall mid-stream.
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain("burst_drain");

      // Reset with two transactions in flight.
      send(24'h123456, 24'h111111, 0, 0, 0);
      send(24'h0ABCDE, 24'h000123, 1, 0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("flush_out_valid", out_valid, 0);
      check("flush_sum", sum, 0);
      check("flush_in_ready", in_ready, 1);
      repeat (6) @(posedge clk);
      #1;

      // Randomized traffic with random backpressure.
      rand_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end else begin
                  send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
               end
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      wait_drain("final_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fa_pipe_seg.md
FA_PIPE_SEG -- requirements
Module: fa_pipe_seg

Interface
REQ-001 SHALL have parameter WIDTH, default 24, total operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 12, segment width; WIDTH SHALL be an integer multiple of SEG; NSEG = WIDTH/SEG (derived, 1..8 supported).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  operand transaction offered.
REQ-006 SHALL have port IN_READY  output  1  block accepts a transaction this cycle.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B.
REQ-009 SHALL have port CIN  input  1  carry-in; ignored when SUB=1.
REQ-010 SHALL have port SUB  input  1  0 = A+B+CIN, 1 = A-B.
REQ-011 SHALL have port SAT  input  1  1 = signed saturation on overflow.
REQ-012 SHALL have port OUT_VALID  output  1  result valid.
REQ-013 SHALL have port OUT_READY  input  1  downstream accepts result.
REQ-014 SHALL have port SUM  output  WIDTH  result.
REQ-015 SHALL have port COUT  output  1  carry out of MSB (SUB: 1 = no borrow).
REQ-016 SHALL have port OVF  output  1  two's-complement signed overflow flag.

Function
REQ-017 SHALL implement NSEG pipeline stages; stage k (k=0..NSEG-1) adds segment k (bits k*SEG+SEG-1 : k*SEG) using the carry registered from stage k-1 (stage 0 uses carry-in).
REQ-018 SHALL delay (skew) unprocessed upper operand segments and already-computed lower result segments so each transaction's bits emerge aligned.
REQ-019 SHALL, when SUB=1, use ~B and force stage-0 carry-in to 1; when SUB=0, use B and CIN.
REQ-020 SHALL compute OVF = (sign of A == sign of effective B) and (sign of raw SUM != sign of A), evaluated in the last stage.
REQ-021 SHALL, when SAT=1 and OVF=1, output SUM = 0 followed by WIDTH-1 ones if A's sign is 0, else 1 followed by WIDTH-1 zeros; COUT and OVF unaffected by SAT.
REQ-022 SHALL, when SAT=0, output raw modulo-2^WIDTH SUM.
REQ-023 SHALL carry SUB, SAT and sign bits through the pipeline with their transaction.
REQ-024 SHALL define advance = (!OUT_VALID) || OUT_READY; IN_READY = advance (combinational).
REQ-025 SHALL accept a transaction on a rising edge where IN_VALID && IN_READY; stages shift only when advance=1; bubbles are not collapsed.
REQ-026 SHALL, when advance=0, hold all stage registers, SUM, COUT, OVF, OUT_VALID unchanged.
REQ-027 SHALL have latency NSEG cycles: accepted at edge t with no stall -> OUT_VALID=1 after edge t+NSEG-1... i.e. visible in the cycle following edge t+NSEG-1 for NSEG=1 (registered once).
REQ-028 SHALL sustain throughput of one transaction per cycle when OUT_READY=1.
REQ-029 SHALL deliver results in acceptance order, never dropping or duplicating.
REQ-030 SHALL, for NSEG=1, behave as a single registered stage with latency 1.

Reset
REQ-031 SHALL, on a rising edge with RST_N=0, clear all stage valid bits, OUT_VALID=0, SUM=0, COUT=0, OVF=0, all carry registers=0.
REQ-032 SHALL discard in-flight transactions on reset; none emerge afterwards.
REQ-033 SHALL drive IN_READY=1 in the first cycle after reset release (OUT_VALID=0).

Verification
REQ-034 SHALL cover: A=0x000FFF, B=0x000001, CIN=0, SUB=0 -> SUM=0x001000, COUT=0, OVF=0, 2 cycles after acceptance (cross-segment carry).
REQ-035 SHALL cover: A=0xFFFFFF, B=0x000001, SUB=0 -> SUM=0x000000, COUT=1, OVF=0.
REQ-036 SHALL cover: A=0x7FFFFF, B=0x000001, SUB=0, SAT=0 -> SUM=0x800000, OVF=1; same with SAT=1 -> SUM=0x7FFFFF, OVF=1.
REQ-037 SHALL cover: A=0x000000, B=0x000001, SUB=1 -> SUM=0xFFFFFF, COUT=0, OVF=0; A=0x800000, B=0x000001, SUB=1, SAT=1 -> SUM=0x800000, OVF=1.
REQ-038 SHALL cover: 8 back-to-back transactions, OUT_READY low 3 cycles mid-stream -> IN_READY=0 while stalled with OUT_VALID=1, outputs held, all 8 emerge in order.
REQ-039 SHALL cover: RST_N low for one edge with 2 transactions in flight -> OUT_VALID=0, SUM=0 next cycle, no stale result later.
